// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit pipelined MIPS: latches decode controls and operands,
// detects load-use hazards (one bubble + stall), and bubbles the ID slot on a taken-branch flush.
module id_ex_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          RegWrite,
  input  logic [1:0]    RegDst,
  input  logic          ALUSrc,
  input  logic [1:0]    ALUOp,
  input  logic          Branch,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [1:0]    MemtoReg,
  input  logic [15:0]   instr_id,
  input  logic [DW-1:0] pc2_id,
  input  logic [DW-1:0] rd1_id,
  input  logic [DW-1:0] rd2_id,
  input  logic          flush,
  output logic          stall,
  output logic          ex_RegWrite,
  output logic [1:0]    ex_RegDst,
  output logic          ex_ALUSrc,
  output logic [1:0]    ex_ALUOp,
  output logic          ex_Branch,
  output logic          ex_MemWrite,
  output logic          ex_MemRead,
  output logic [1:0]    ex_MemtoReg,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_pc2,
  output logic [DW-1:0] ex_imm,
  output logic [2:0]    ex_rs,
  output logic [2:0]    ex_rt,
  output logic [2:0]    ex_rd,
  output logic [3:0]    ex_funct,
  output logic          ex_valid,
  output logic [CW-1:0] stall_count
);

  logic [2:0] op;
  logic [2:0] rs;
  logic [2:0] rt;
  logic       uses_rs;
  logic       uses_rt;
  logic       bubble;

  assign op = instr_id[15:13];
  assign rs = instr_id[12:10];
  assign rt = instr_id[9:7];

  // The all-zero NOP decodes as op 0 but reads nothing, so it must not trigger a stall.
  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    if (instr_id != '0) begin
      case (op)
        3'd0, 3'd2, 3'd6: begin
          uses_rs = 1'b1;
          uses_rt = 1'b1;
        end
        3'd3, 3'd5: uses_rs = 1'b1;
        default: ;
      endcase
    end
  end

  assign stall = ex_MemRead & ex_valid & ~flush &
                 ((uses_rs & (ex_rt == rs)) | (uses_rt & (ex_rt == rt)));

  assign bubble = flush | stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_RegWrite <= 1'b0;
      ex_RegDst   <= '0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOp    <= '0;
      ex_Branch   <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemtoReg <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_pc2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
      ex_valid    <= 1'b0;
    end else if (bubble) begin
      ex_RegWrite <= 1'b0;
      ex_RegDst   <= '0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOp    <= '0;
      ex_Branch   <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemtoReg <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_pc2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
      ex_valid    <= 1'b0;
    end else begin
      ex_RegWrite <= RegWrite;
      ex_RegDst   <= RegDst;
      ex_ALUSrc   <= ALUSrc;
      ex_ALUOp    <= ALUOp;
      ex_Branch   <= Branch;
      ex_MemWrite <= MemWrite;
      ex_MemRead  <= MemRead;
      ex_MemtoReg <= MemtoReg;
      ex_rd1      <= rd1_id;
      ex_rd2      <= rd2_id;
      ex_pc2      <= pc2_id;
      ex_imm      <= {{(DW-7){instr_id[6]}}, instr_id[6:0]};
      ex_rs       <= rs;
      ex_rt       <= rt;
      ex_rd       <= instr_id[6:4];
      ex_funct    <= instr_id[3:0];
      ex_valid    <= (instr_id != '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use stall, flush priority, pass-through,
// async reset and stall-counter saturation (second instance with a 4-bit counter).
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        RegWrite, ALUSrc, Branch, MemWrite, MemRead, flush;
  logic [1:0]  RegDst, ALUOp, MemtoReg;
  logic [15:0] instr_id, pc2_id, rd1_id, rd2_id;

  logic        stall, ex_RegWrite, ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_valid;
  logic [1:0]  ex_RegDst, ex_ALUOp, ex_MemtoReg;
  logic [15:0] ex_rd1, ex_rd2, ex_pc2, ex_imm, stall_count;
  logic [2:0]  ex_rs, ex_rt, ex_rd;
  logic [3:0]  ex_funct;

  logic        s_stall, s_RegWrite, s_ALUSrc, s_Branch, s_MemWrite, s_MemRead, s_valid;
  logic [1:0]  s_RegDst, s_ALUOp, s_MemtoReg;
  logic [15:0] s_rd1, s_rd2, s_pc2, s_imm;
  logic [2:0]  s_rs, s_rt, s_rd;
  logic [3:0]  s_funct;
  logic [3:0]  s_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  id_ex_stage #(.DW(16), .CW(16)) dut (
    .clock(clock), .reset(reset),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .Branch(Branch), .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .instr_id(instr_id), .pc2_id(pc2_id), .rd1_id(rd1_id), .rd2_id(rd2_id), .flush(flush),
    .stall(stall),
    .ex_RegWrite(ex_RegWrite), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .ex_Branch(ex_Branch), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_pc2(ex_pc2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_valid(ex_valid), .stall_count(stall_count)
  );

  id_ex_stage #(.DW(16), .CW(4)) dut_sat (
    .clock(clock), .reset(reset),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .Branch(Branch), .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .instr_id(instr_id), .pc2_id(pc2_id), .rd1_id(rd1_id), .rd2_id(rd2_id), .flush(flush),
    .stall(s_stall),
    .ex_RegWrite(s_RegWrite), .ex_RegDst(s_RegDst), .ex_ALUSrc(s_ALUSrc), .ex_ALUOp(s_ALUOp),
    .ex_Branch(s_Branch), .ex_MemWrite(s_MemWrite), .ex_MemRead(s_MemRead), .ex_MemtoReg(s_MemtoReg),
    .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_pc2(s_pc2), .ex_imm(s_imm),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_funct(s_funct),
    .ex_valid(s_valid), .stall_count(s_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic rw, input logic [1:0] rdst,
                       input logic asrc, input logic [1:0] aop, input logic br,
                       input logic mw, input logic mr, input logic [1:0] m2r);
    instr_id = instr; RegWrite = rw; RegDst = rdst; ALUSrc = asrc; ALUOp = aop;
    Branch = br; MemWrite = mw; MemRead = mr; MemtoReg = m2r;
  endtask

  // lw r2,0(r1)
  task automatic drive_lw();
    drive(16'hA500, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1);
  endtask

  // add r3,r2,r4
  task automatic drive_add();
    drive(16'h0A30, 1'b1, 2'd1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    pc2_id = 16'h0010; rd1_id = 16'h1111; rd2_id = 16'h2222;
    drive(16'h0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    #12;
    check("rst_valid", ex_valid, 0);
    check("rst_count", stall_count, 0);
    check("rst_stall", stall, 0);
    reset = 1'b0;
    tick();

    // load-use on rs
    drive_lw();
    #1 check("lw_nostall", stall, 0);
    tick();
    check("lw_memread", ex_MemRead, 1);
    check("lw_rt", ex_rt, 2);
    drive_add();
    #1 check("lu_stall", stall, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_rw", ex_RegWrite, 0);
    check("lu_count", stall_count, 1);
    check("lu_stall_drop", stall, 0);
    tick();
    check("lu_add_rs", ex_rs, 2);
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_regdst", ex_RegDst, 1);
    check("lu_add_count", stall_count, 1);

    // store uses rt as a source
    drive_lw();
    tick();
    drive(16'hD900, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1 check("sw_stall", stall, 1);
    tick();
    check("sw_bubble_mw", ex_MemWrite, 0);
    check("sw_stall_drop", stall, 0);
    tick();
    check("sw_memwrite", ex_MemWrite, 1);
    check("sw_count", stall_count, 2);

    // addi r2,r3,#4: rt is a destination, not a source
    drive_lw();
    tick();
    drive(16'h6D04, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    #1 check("addi_nostall", stall, 0);
    tick();
    check("addi_valid", ex_valid, 1);
    // jal with rs/rt bits equal to 2 still has no sources
    drive_lw();
    tick();
    drive(16'h2900, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2);
    #1 check("jal_nostall", stall, 0);
    tick();
    check("jal_memtoreg", ex_MemtoReg, 2);
    check("jal_count", stall_count, 2);

    // flush beats stall
    drive_lw();
    tick();
    drive_add();
    flush = 1'b1;
    #1 check("fl_stall", stall, 0);
    tick();
    flush = 1'b0;
    check("fl_valid", ex_valid, 0);
    check("fl_rw", ex_RegWrite, 0);
    check("fl_rs", ex_rs, 0);
    check("fl_count", stall_count, 2);

    // beq r1,r2,-3 pass-through
    rd1_id = 16'h1234; rd2_id = 16'hABCD; pc2_id = 16'h0042;
    drive(16'h457D, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0);
    #1 check("beq_nostall", stall, 0);
    tick();
    check("beq_branch", ex_Branch, 1);
    check("beq_aluop", ex_ALUOp, 1);
    check("beq_imm", ex_imm, 16'hFFFD);
    check("beq_rd1", ex_rd1, 16'h1234);
    check("beq_rd2", ex_rd2, 16'hABCD);
    check("beq_pc2", ex_pc2, 16'h0042);
    check("beq_rs", ex_rs, 1);
    check("beq_rt", ex_rt, 2);
    check("beq_funct", ex_funct, 4'hD);
    check("beq_valid", ex_valid, 1);

    // all-zero instruction is a bubble
    drive(16'h0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    check("nop_valid", ex_valid, 0);

    // lw r2,0(r2) held: stalls every other cycle, 20 stalls
    drive(16'hA900, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (i == 0) check("sat_first_nostall", stall, 0);
      if (i == 1) check("sat_first_stall", stall, 1);
      tick();
    end
    check("sat_count4", s_count, 15);
    check("sat_count16", stall_count, 22);
    tick();
    check("pend_memread", ex_MemRead, 1);
    check("pend_stall", stall, 1);

    // asynchronous reset with a load pending
    #2 reset = 1'b1;
    #1;
    check("arst_memread", ex_MemRead, 0);
    check("arst_rw", ex_RegWrite, 0);
    check("arst_rt", ex_rt, 0);
    check("arst_rd1", ex_rd1, 0);
    check("arst_valid", ex_valid, 0);
    check("arst_count", stall_count, 0);
    check("arst_scount", s_count, 0);
    check("arst_stall", stall, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
